mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and handshake sequencer that shares the single ram512x8 port between instruction fetch and data load/store. It sits between the DataPath control unit's fetch and data-access requests and the RAM's MOV/MOC/RW/OpC interface. It drives exactly one memory transaction at a time and resolves conflicts round-robin. It also enforces a MOC timeout so a missing completion cannot hang the CPU.

## Interface
- ADDR_W, 9, memory address width (matches 512-byte RAM)
- TIMEOUT, 15, max cycles in WAIT without MOC before error completion (1..255)
- I_OPC, 6'b100011, OpC driven for fetches (word load)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched word, valid while i_ack=1, held until next fetch capture
- d_req  in  1  data request, level, held until d_ack
- d_rw  in  1  1=read, 0=write (same sense as RAM RW)
- d_opc  in  6  access-size opcode passed to RAM
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data, valid while d_ack=1
- d_err  out  1  high with d_ack/i_ack when completion was by timeout
- mem_mov  out  1  RAM memory-operation-valid
- mem_rw  out  1  RAM read/write
- mem_addr  out  ADDR_W  RAM address
- mem_opc  out  6  RAM access opcode
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data
- mem_moc  in  1  RAM memory-operation-complete

## Operation
- States: IDLE, WAIT, DONE. Register last_grant (0=fetch, 1=data).
- IDLE: if mem_moc=1, stay (RAM still releasing previous op). Else if exactly one req high, grant it. If both high, grant the one not equal to last_grant. On grant: latch addr/rw/opc/wdata into mem_* registers, set mem_mov=1, update last_grant, clear timeout counter, go WAIT.
- Fetch grant: mem_rw=1, mem_opc=I_OPC, mem_wdata=0.
- WAIT: mem_* held stable. On mem_moc=1: capture mem_rdata into granted rdata register (reads only; writes leave it unchanged), mem_mov=0, go DONE, err=0. Else counter+1; when counter reaches TIMEOUT: mem_mov=0, go DONE, err=1, rdata unchanged.
- DONE: assert granted ack (and d_err=err) for exactly one cycle, then IDLE. Requests sampled in DONE are ignored.
- Requester must drop req on the edge ending its ack cycle; a req still high in IDLE starts a new transaction.
- Requests changing while not granted have no effect on the active transaction.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant=1 (first tie goes to fetch), counter 0, rdata registers 0.
- Reset asserted mid-transaction: mem_mov drops asynchronously, no ack issued, transaction abandoned.
- Grant latency: req sampled at edge N in IDLE -> mem_mov=1 after edge N.
- Completion: mem_moc sampled high at edge M -> mem_mov=0 and state DONE after M; ack high M..M+1; IDLE after M+1.
- Minimum transaction: 3 cycles req-to-IDLE (MOC on first WAIT edge).
- Timeout: ack with d_err=1 exactly TIMEOUT+1 edges after grant when MOC never rises.
- Back-to-back with both requesting: alternating grants, one IDLE cycle between transactions; no requester waits more than one transaction.
- mem_moc high while in DONE or IDLE: no grant until it falls; no spurious ack.

## Test plan
- Reset then i_req=1, i_addr=0x004, RAM preloaded 0x8C220004 -> mem_mov=1, mem_rw=1, mem_opc=100011, i_ack pulse with i_rdata=0x8C220004, d_ack never high.
- d_req write, d_addr=0x010, d_opc=101011, d_wdata=0xDEADBEEF, then fetch 0x010 -> d_ack with d_err=0; subsequent i_rdata=0xDEADBEEF.
- i_req and d_req both held high from reset -> grant order fetch, data, fetch, data; acks alternate, each one cycle.
- RAM MOC forced low, d_req read -> d_ack and d_err high 16 edges after grant (TIMEOUT=15), mem_mov low, d_rdata unchanged.
- mem_moc held high after a completion for 3 cycles with i_req=1 -> no mem_mov until mem_moc falls, then normal fetch.
- reset pulsed low during WAIT -> mem_mov, all acks 0 immediately; after release, pending req re-granted cleanly.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Memory-side bus between the arbiter and the single ram512x8 port.
//   master : arbiter side (drives the operation, receives data/completion)
//   slave  : RAM side
//   Signals:
//     mem_mov   master->slave  memory-operation-valid
//     mem_rw    master->slave  1=read, 0=write
//     mem_addr  master->slave  byte address (ADDR_W bits)
//     mem_opc   master->slave  access-size opcode
//     mem_wdata master->slave  store data
//     mem_rdata slave->master  load data
//     mem_moc   slave->master  memory-operation-complete
interface mem_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              mem_mov;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [5:0]        mem_opc;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_moc;

    modport master (
        output mem_mov,
        output mem_rw,
        output mem_addr,
        output mem_opc,
        output mem_wdata,
        input  mem_rdata,
        input  mem_moc
    );

    modport slave (
        input  mem_mov,
        input  mem_rw,
        input  mem_addr,
        input  mem_opc,
        input  mem_wdata,
        output mem_rdata,
        output mem_moc
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one RAM port between instruction fetch and data load/store.
//   One transaction at a time, round-robin on simultaneous requests, and a
//   MOC timeout that completes the transaction with an error flag.
//   Ports:
//     clk      system clock, rising edge
//     reset    asynchronous, active-low
//     i_req/i_addr            fetch request (level, held until i_ack)
//     i_ack/i_rdata           fetch completion pulse / fetched word
//     d_req/d_rw/d_opc/d_addr/d_wdata   data request
//     d_ack/d_rdata           data completion pulse / load data
//     d_err                   high with the ack when completion was by timeout
//     mem                     RAM bus (mem_arbiter_if.master)
module mem_arbiter #(
    parameter int          ADDR_W  = 9,
    parameter int          TIMEOUT = 15,
    parameter logic [5:0]  I_OPC   = 6'b100011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [5:0]        d_opc,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    mem_arbiter_if.master     mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;  // 0 = fetch, 1 = data
    logic       cur_grant;   // owner of the transaction in flight
    logic [7:0] cnt;

    logic do_grant;
    logic pick_data;

    // Grant decision. A high MOC in IDLE means the RAM is still releasing
    // the previous operation, so nothing is granted until it falls.
    always_comb begin
        do_grant  = 1'b0;
        pick_data = 1'b0;
        if (!mem.mem_moc) begin
            if (i_req && d_req) begin
                do_grant  = 1'b1;
                pick_data = ~last_grant;
            end else if (i_req) begin
                do_grant  = 1'b1;
                pick_data = 1'b0;
            end else if (d_req) begin
                do_grant  = 1'b1;
                pick_data = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            cur_grant     <= 1'b0;
            cnt           <= '0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            d_err         <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            mem.mem_mov   <= 1'b0;
            mem.mem_rw    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_opc   <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    d_err <= 1'b0;
                    if (do_grant) begin
                        state       <= WAIT;
                        cur_grant   <= pick_data;
                        last_grant  <= pick_data;
                        cnt         <= '0;
                        mem.mem_mov <= 1'b1;
                        if (pick_data) begin
                            mem.mem_rw    <= d_rw;
                            mem.mem_addr  <= d_addr;
                            mem.mem_opc   <= d_opc;
                            mem.mem_wdata <= d_wdata;
                        end else begin
                            mem.mem_rw    <= 1'b1;
                            mem.mem_addr  <= i_addr;
                            mem.mem_opc   <= I_OPC;
                            mem.mem_wdata <= '0;
                        end
                    end
                end

                WAIT: begin
                    if (mem.mem_moc) begin
                        mem.mem_mov <= 1'b0;
                        state       <= DONE;
                        d_err       <= 1'b0;
                        if (cur_grant) begin
                            d_ack <= 1'b1;
                            if (mem.mem_rw) begin
                                d_rdata <= mem.mem_rdata;
                            end
                        end else begin
                            i_ack <= 1'b1;
                            if (mem.mem_rw) begin
                                i_rdata <= mem.mem_rdata;
                            end
                        end
                    end else if (cnt == 8'(TIMEOUT)) begin
                        // Comparing before the increment makes the error
                        // ack land TIMEOUT+1 edges after the grant.
                        mem.mem_mov <= 1'b0;
                        state       <= DONE;
                        d_err       <= 1'b1;
                        if (cur_grant) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    d_err <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural RAM responder and a
//   scoreboard of expected completions checked when acks appear.
module tb_mem_arbiter;

    localparam int         ADDR_W  = 9;
    localparam int         TIMEOUT = 15;
    localparam logic [5:0] I_OPC   = 6'b100011;
    localparam logic [5:0] OPC_SW  = 6'b101011;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_rw = 1'b0;
    logic [5:0]        d_opc = '0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) mem_bus ();

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .I_OPC  (I_OPC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_ack  (i_ack),
        .i_rdata(i_rdata),
        .d_req  (d_req),
        .d_rw   (d_rw),
        .d_opc  (d_opc),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_ack  (d_ack),
        .d_rdata(d_rdata),
        .d_err  (d_err),
        .mem    (mem_bus)
    );

    always #5 clk = ~clk;

    int unsigned checks_total  = 0;
    int unsigned checks_passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- RAM responder ----------------
    logic [31:0] ram [0:511];
    bit          moc_force_low = 1'b0;
    int unsigned moc_hold = 0;

    initial begin
        mem_bus.mem_moc   = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                mem_bus.mem_moc = 1'b0;
            end else if (mem_bus.mem_mov && !mem_bus.mem_moc && !moc_force_low) begin
                if (mem_bus.mem_rw) mem_bus.mem_rdata = ram[mem_bus.mem_addr];
                else                ram[mem_bus.mem_addr] = mem_bus.mem_wdata;
                mem_bus.mem_moc = 1'b1;
            end else if (!mem_bus.mem_mov && mem_bus.mem_moc) begin
                if (moc_hold > 0) moc_hold--;
                else              mem_bus.mem_moc = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] i_rdata_m = '0;
    logic [31:0] d_rdata_m = '0;

    task automatic push_exp(input bit is_data, input bit rw, input logic [ADDR_W-1:0] addr,
                            input bit err);
        exp_t e;
        e.is_data = is_data;
        e.err     = err;
        if (rw && !err) begin
            if (is_data) d_rdata_m = ram[addr];
            else         i_rdata_m = ram[addr];
        end
        e.rdata = is_data ? d_rdata_m : i_rdata_m;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset && (i_ack || d_ack)) begin
                chk("sb_expected_ack", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("ack_data_side",  32'(d_ack), 32'(mon_e.is_data));
                    chk("ack_fetch_side", 32'(i_ack), 32'(!mon_e.is_data));
                    chk("ack_err",        32'(d_err), 32'(mon_e.err));
                    chk("ack_rdata", mon_e.is_data ? d_rdata : i_rdata, mon_e.rdata);
                    chk("mov_low_at_ack", 32'(mem_bus.mem_mov), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_grant(input bit is_data, input bit rw, input logic [5:0] opc,
                               input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        chk("grant_mov",  32'(mem_bus.mem_mov), 32'd1);
        chk("grant_rw",   32'(mem_bus.mem_rw), is_data ? 32'(rw) : 32'd1);
        chk("grant_opc",  32'(mem_bus.mem_opc), is_data ? 32'(opc) : 32'(I_OPC));
        chk("grant_addr", 32'(mem_bus.mem_addr), 32'(addr));
        chk("grant_wdata", mem_bus.mem_wdata, is_data ? wdata : 32'd0);
    endtask

    task automatic wait_ack(output int n);
        bit found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            if (i_ack || d_ack) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) chk("ack_arrived", 32'd0, 32'd1);
    endtask

    // Entered at a negedge with the arbiter idle; returns one negedge after the ack.
    task automatic run_txn(input bit is_data, input bit rw, input logic [5:0] opc,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                           input bit exp_err, input int exp_lat);
        int n;
        push_exp(is_data, rw, addr, exp_err);
        if (is_data) begin
            d_req = 1'b1; d_rw = rw; d_opc = opc; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(negedge clk);
        check_grant(is_data, rw, opc, addr, wdata);
        wait_ack(n);
        chk("ack_latency", 32'(n), 32'(exp_lat));
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", {30'd0, i_ack, d_ack}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int w;

        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[4] = 32'h8C220004;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_i_ack",   32'(i_ack), 32'd0);
        chk("rst_d_ack",   32'(d_ack), 32'd0);
        chk("rst_d_err",   32'(d_err), 32'd0);
        chk("rst_mov",     32'(mem_bus.mem_mov), 32'd0);
        chk("rst_rw",      32'(mem_bus.mem_rw), 32'd0);
        chk("rst_addr",    32'(mem_bus.mem_addr), 32'd0);
        chk("rst_opc",     32'(mem_bus.mem_opc), 32'd0);
        chk("rst_wdata",   mem_bus.mem_wdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch
        run_txn(1'b0, 1'b1, I_OPC, 9'h004, 32'h0, 1'b0, 1);

        // Store then fetch it back
        run_txn(1'b1, 1'b0, OPC_SW, 9'h010, 32'hDEADBEEF, 1'b0, 1);
        run_txn(1'b0, 1'b1, I_OPC, 9'h010, 32'h0, 1'b0, 1);

        // Both requesting from reset: fetch, data, fetch, data
        reset = 1'b0;
        #2;
        i_rdata_m = '0;
        d_rdata_m = '0;
        i_req = 1'b1; i_addr = 9'h004;
        d_req = 1'b1; d_rw = 1'b1; d_opc = I_OPC; d_addr = 9'h010; d_wdata = 32'h0;
        push_exp(1'b0, 1'b1, 9'h004, 1'b0);
        push_exp(1'b1, 1'b1, 9'h010, 1'b0);
        push_exp(1'b0, 1'b1, 9'h004, 1'b0);
        push_exp(1'b1, 1'b1, 9'h010, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rr_first_addr", 32'(mem_bus.mem_addr), 32'h004);
        wait_ack(n);
        chk("rr_first_latency", 32'(n), 32'd1);
        for (int g = 1; g < 4; g++) begin
            @(negedge clk);
            wait_ack(n);
            chk("rr_gap", 32'(n + 1), 32'd3);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rr_no_extra_grant", 32'(mem_bus.mem_mov), 32'd0);
        end

        // MOC never arrives: timeout completion, d_rdata unchanged
        moc_force_low = 1'b1;
        run_txn(1'b1, 1'b1, I_OPC, 9'h004, 32'h0, 1'b1, TIMEOUT + 1);
        moc_force_low = 1'b0;
        @(negedge clk);

        // MOC lingers after completion: next fetch held off until it falls
        moc_hold = 3;
        run_txn(1'b0, 1'b1, I_OPC, 9'h010, 32'h0, 1'b0, 1);
        i_req = 1'b1; i_addr = 9'h004;
        push_exp(1'b0, 1'b1, 9'h004, 1'b0);
        w = 0;
        while (mem_bus.mem_moc && w < 10) begin
            chk("no_grant_while_moc", 32'(mem_bus.mem_moc ? mem_bus.mem_mov : 1'b0), 32'd0);
            @(negedge clk);
            w++;
        end
        chk("moc_hold_cycles", 32'(w), 32'd2);
        chk("no_grant_moc_fall_edge", 32'(mem_bus.mem_mov), 32'd0);
        @(negedge clk);
        check_grant(1'b0, 1'b1, I_OPC, 9'h004, 32'h0);
        wait_ack(n);
        chk("post_hold_latency", 32'(n), 32'd1);
        i_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT: abandoned, then re-granted cleanly
        moc_force_low = 1'b1;
        d_req = 1'b1; d_rw = 1'b1; d_opc = I_OPC; d_addr = 9'h004; d_wdata = 32'h0;
        @(negedge clk);
        chk("pre_reset_mov", 32'(mem_bus.mem_mov), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_mov",     32'(mem_bus.mem_mov), 32'd0);
        chk("async_rst_acks",    {30'd0, i_ack, d_ack}, 32'd0);
        chk("async_rst_d_rdata", d_rdata, 32'd0);
        i_rdata_m = '0;
        d_rdata_m = '0;
        moc_force_low = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_exp(1'b1, 1'b1, 9'h004, 1'b0);
        @(negedge clk);
        check_grant(1'b1, 1'b1, I_OPC, 9'h004, 32'h0);
        wait_ack(n);
        chk("regrant_latency", 32'(n), 32'd1);
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
